// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS RW registers, a read-only ID and a transfer counter.
// Define APB_SLVERR_EN to flag illegal accesses on PSLVERR.
module apb_slave_regfile #(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA7B0_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR
);

    localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] ID_OFF    = 32'(NUM_REGS * 4);
    localparam logic [31:0] CNT_OFF   = ID_OFF + 32'd4;
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               write_q;
    logic [31:0]        xfer_cnt;
    logic [31:0]        regs [NUM_REGS];

    logic [31:0]        dec_addr;
    logic               dec_write;
    logic [31:0]        off;
    logic               hit_rw;
    logic               hit_id;
    logic               hit_cnt;
    logic [IDX_W-1:0]   idx;
    logic               illegal;
    logic [31:0]        resp_data;
    logic               resp_err;
    logic               setup;

    assign setup = PSEL && !PENABLE;

    // In IDLE the decode looks at the live bus so a zero-wait response can be
    // produced on the setup edge; afterwards it uses the latched transfer.
    always_comb begin
        dec_addr  = (state == ST_IDLE) ? PADDR  : addr_q;
        dec_write = (state == ST_IDLE) ? PWRITE : write_q;
        off       = dec_addr - BASE_ADDR;
        hit_rw    = (off < ID_OFF) && (off[1:0] == 2'b00);
        hit_id    = (off == ID_OFF);
        hit_cnt   = (off == CNT_OFF);
        idx       = off[IDX_W+1:2];
        illegal   = !(hit_rw || hit_id || hit_cnt) || (dec_write && !hit_rw);
        resp_data = '0;
        if (!dec_write) begin
            if (hit_rw)
                resp_data = regs[idx];
            else if (hit_id)
                resp_data = ID_VALUE;
            else if (hit_cnt)
                resp_data = xfer_cnt;
        end
`ifdef APB_SLVERR_EN
        resp_err = illegal;
`else
        resp_err = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            xfer_cnt <= '0;
            PREADY   <= 1'b0;
            PRDATA   <= '0;
            PSLVERR  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        addr_q  <= PADDR;
                        wdata_q <= PWDATA;
                        write_q <= PWRITE;
                        if (WAIT_CYCLES == 0) begin
                            state   <= ST_RESP;
                            PREADY  <= 1'b1;
                            PRDATA  <= resp_data;
                            PSLVERR <= resp_err;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state   <= ST_RESP;
                        PREADY  <= 1'b1;
                        PRDATA  <= resp_data;
                        PSLVERR <= resp_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (dec_write && !illegal)
                        regs[idx] <= wdata_q;
                    xfer_cnt <= xfer_cnt + 32'd1;
                    PREADY   <= 1'b0;
                    PRDATA   <= '0;
                    PSLVERR  <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: two instances (zero and three wait states) driven with directed APB transfers.
module tb_apb_slave_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef APB_SLVERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        bit          chk;
        bit          err;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic        rst0_n, rst3_n;
    logic        p0_psel, p0_penable, p0_pwrite, p0_pready, p0_pslverr;
    logic [31:0] p0_paddr, p0_pwdata, p0_prdata;
    logic        p3_psel, p3_penable, p3_pwrite, p3_pready, p3_pslverr;
    logic [31:0] p3_paddr, p3_pwdata, p3_prdata;

    apb_slave_regfile #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(0), .ID_VALUE(32'hA7B0_0001)) dut0 (
        .clk(clk), .rst_n(rst0_n), .PSEL(p0_psel), .PENABLE(p0_penable), .PWRITE(p0_pwrite),
        .PADDR(p0_paddr), .PWDATA(p0_pwdata), .PREADY(p0_pready), .PRDATA(p0_prdata), .PSLVERR(p0_pslverr));

    apb_slave_regfile #(.NUM_REGS(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(3), .ID_VALUE(32'hA7B0_0001)) dut3 (
        .clk(clk), .rst_n(rst3_n), .PSEL(p3_psel), .PENABLE(p3_penable), .PWRITE(p3_pwrite),
        .PADDR(p3_paddr), .PWDATA(p3_pwdata), .PREADY(p3_pready), .PRDATA(p3_prdata), .PSLVERR(p3_pslverr));

    // Response monitors: every PREADY pops one expectation.
    always @(negedge clk) begin
        if (p0_pready) begin
            compared++;
            if (q0.size() == 0) begin
                mismatched++;
                $display("FAIL dut0 unexpected response prdata=%h pslverr=%b", p0_prdata, p0_pslverr);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if ((e.chk && p0_prdata !== e.data) || p0_pslverr !== e.err) begin
                    mismatched++;
                    $display("FAIL dut0 resp prdata=%h exp %h pslverr=%b exp %b", p0_prdata, e.data, p0_pslverr, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (p3_pready) begin
            compared++;
            if (q3.size() == 0) begin
                mismatched++;
                $display("FAIL dut3 unexpected response prdata=%h pslverr=%b", p3_prdata, p3_pslverr);
            end else begin
                exp_t e;
                e = q3.pop_front();
                if ((e.chk && p3_prdata !== e.data) || p3_pslverr !== e.err) begin
                    mismatched++;
                    $display("FAIL dut3 resp prdata=%h exp %h pslverr=%b exp %b", p3_prdata, e.data, p3_pslverr, e.err);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit sel, input bit en, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            p0_psel = sel; p0_penable = en; p0_pwrite = wr; p0_paddr = a; p0_pwdata = wd;
        end else begin
            p3_psel = sel; p3_penable = en; p3_pwrite = wr; p3_paddr = a; p3_pwdata = wd;
        end
    endtask

    function automatic bit rdy(input int d);
        return (d == 0) ? p0_pready : p3_pready;
    endfunction

    // Called just after a rising edge; leaves the bus idle just after the edge ending RESP.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input bit ee, input int ew, input bit scramble);
        exp_t e;
        int   waits;
        e.data = ed; e.chk = !wr; e.err = ee;
        if (d == 0) q0.push_back(e); else q3.push_back(e);
        drive(d, 1'b1, 1'b0, wr, a, wd);
        @(posedge clk); #1;
        if (scramble) drive(d, 1'b1, 1'b1, wr, a ^ 32'h4, ~wd);
        else          drive(d, 1'b1, 1'b1, wr, a, wd);
        waits = 0;
        while (!rdy(d) && waits <= 20) begin
            @(posedge clk); #1;
            waits++;
        end
        check($sformatf("latency d%0d a=%h", d, a), 32'(waits), 32'(ew));
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(3, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst pready0", 32'(p0_pready), 32'd0);
        check("rst prdata0", p0_prdata, 32'd0);
        check("rst pslverr0", 32'(p0_pslverr), 32'd0);
        check("rst pready3", 32'(p3_pready), 32'd0);
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait instance: reset contents, ID, write/readback, counter, illegal accesses.
        for (int i = 0; i < 8; i++)
            xfer(0, 1'b0, 32'(i * 4), '0, 32'd0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h20, '0, 32'hA7B0_0001, 1'b0, 0, 1'b0);
        xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, '0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h04, '0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h00, '0, 32'd0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h08, '0, 32'd0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h24, '0, 32'd13, 1'b0, 0, 1'b0);
        xfer(0, 1'b1, 32'h20, 32'h5555_AAAA, '0, ERR, 0, 1'b0);
        xfer(0, 1'b0, 32'h20, '0, 32'hA7B0_0001, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h02, '0, 32'd0, ERR, 0, 1'b0);
        xfer(0, 1'b1, 32'h24, 32'd0, '0, ERR, 0, 1'b0);
        xfer(0, 1'b0, 32'h28, '0, 32'd0, ERR, 0, 1'b0);
        xfer(0, 1'b1, 32'h1C, 32'h0BAD_F00D, '0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h1C, '0, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h24, '0, 32'd21, 1'b0, 0, 1'b0);
        xfer(0, 1'b1, 32'h05, 32'hFFFF_FFFF, '0, ERR, 0, 1'b0);
        xfer(0, 1'b0, 32'h04, '0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h24, '0, 32'd24, 1'b0, 0, 1'b0);

        // Three-wait instance: round trip, bus changes during WAIT, abort.
        xfer(3, 1'b1, 32'h00, 32'hCAFE_F00D, '0, 1'b0, 3, 1'b0);
        xfer(3, 1'b0, 32'h00, '0, 32'hCAFE_F00D, 1'b0, 3, 1'b0);
        xfer(3, 1'b1, 32'h08, 32'h0000_00A5, '0, 1'b0, 3, 1'b1);
        drive(3, 1'b1, 1'b0, 1'b1, 32'h08, 32'h1234_5678);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 32'h08, 32'h1234_5678);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        xfer(3, 1'b0, 32'h08, '0, 32'h0000_00A5, 1'b0, 3, 1'b0);
        xfer(3, 1'b0, 32'h0C, '0, 32'd0, 1'b0, 3, 1'b0);
        xfer(3, 1'b0, 32'h24, '0, 32'd5, 1'b0, 3, 1'b0);
        xfer(3, 1'b0, 32'h20, '0, 32'hA7B0_0001, 1'b0, 3, 1'b0);

        // Reset in the middle of a waited write.
        drive(3, 1'b1, 1'b0, 1'b1, 32'h04, 32'h7777_7777);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 32'h04, 32'h7777_7777);
        @(posedge clk); #3;
        rst3_n = 1'b0;
        #1;
        check("midrst pready3", 32'(p3_pready), 32'd0);
        check("midrst prdata3", p3_prdata, 32'd0);
        check("midrst pslverr3", 32'(p3_pslverr), 32'd0);
        drive(3, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        @(posedge clk); #1;
        xfer(3, 1'b0, 32'h04, '0, 32'd0, 1'b0, 3, 1'b0);
        xfer(3, 1'b0, 32'h00, '0, 32'd0, 1'b0, 3, 1'b0);
        xfer(3, 1'b0, 32'h24, '0, 32'd2, 1'b0, 3, 1'b0);

        repeat (3) @(posedge clk);
        check("dut0 pending responses", 32'(q0.size()), 32'd0);
        check("dut3 pending responses", 32'(q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
